// File: rtl/calx_pkg.sv
// calx_pkg: shared types for the Calx arbiter block.
// Holds the operand bundle, FSM state encoding and default timeout.
package calx_pkg;

    localparam int CALX_TIMEOUT_DEFAULT = 2000;

    typedef struct packed {
        logic [63:0] z;
        logic [63:0] r;
        logic [63:0] dss;
        logic [63:0] z0square;
    } calx_ops_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } calx_state_t;

endpackage

// File: rtl/calx_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a last-winner pointer.
// Pointer resets to requester 1 so requester 0 wins the first tie.
module rr_arb2
    import calx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last;

    // Grant the lone requester, or on a tie the one not served last.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember which requester won the most recent accepted grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (update) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/calx_arbiter.sv
// calx_arbiter: shares one Calx unit between two requesters.
// Optional abort on a stuck Calx with macro CALX_ARB_TIMEOUT_EN.
module calx_arbiter
    import calx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = CALX_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_stb,
    output logic        req0_ack,
    input  logic [63:0] req0_z,
    input  logic [63:0] req0_r,
    input  logic [63:0] req0_dss,
    input  logic [63:0] req0_z0square,
    output logic [63:0] res0_x,
    output logic        res0_stb,
    input  logic        res0_ack,
    output logic        res0_err,
    input  logic        req1_stb,
    output logic        req1_ack,
    input  logic [63:0] req1_z,
    input  logic [63:0] req1_r,
    input  logic [63:0] req1_dss,
    input  logic [63:0] req1_z0square,
    output logic [63:0] res1_x,
    output logic        res1_stb,
    input  logic        res1_ack,
    output logic        res1_err,
    output logic        c_stb,
    output logic [63:0] c_z,
    output logic [63:0] c_r,
    output logic [63:0] c_dss,
    output logic [63:0] c_z0square,
    input  logic        c_ack,
    input  logic [63:0] c_x,
    input  logic        c_x_stb,
    output logic        c_x_ack
);

    calx_state_t state;
    calx_ops_t   ops;
    calx_ops_t   in0;
    calx_ops_t   in1;
    logic        owner;
    logic [1:0]  gnt;
    logic        grant_go;
    logic        tmo;
    logic        load;
    logic [63:0] ret_x;
    logic [63:0] x0;
    logic [63:0] x1;

    assign in0 = {req0_z, req0_r, req0_dss, req0_z0square};
    assign in1 = {req1_z, req1_r, req1_dss, req1_z0square};

    assign grant_go = rst && (state == ST_IDLE) && (|gnt);

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_stb, req0_stb}),
        .update (grant_go),
        .gnt    (gnt)
    );

    assign req0_ack = grant_go && gnt[0];
    assign req1_ack = grant_go && gnt[1];

    assign c_stb      = (state == ST_ISSUE);
    assign c_x_ack    = (state == ST_WAIT);
    assign c_z        = ops.z;
    assign c_r        = ops.r;
    assign c_dss      = ops.dss;
    assign c_z0square = ops.z0square;

    assign res0_stb = (state == ST_RETURN) && !owner;
    assign res1_stb = (state == ST_RETURN) && owner;
    assign res0_x   = x0;
    assign res1_x   = x1;

    // A real Calx result wins; an abort delivers zero.
    assign load  = ((state == ST_WAIT) && c_x_stb) || tmo;
    assign ret_x = ((state == ST_WAIT) && c_x_stb) ? c_x : 64'd0;

`ifdef CALX_ARB_TIMEOUT_EN
    logic [31:0] cnt;
    logic        err_q;

    assign tmo = (cnt == 32'(TIMEOUT_CYCLES - 1))
              && (((state == ST_ISSUE) && !c_ack)
               || ((state == ST_WAIT) && !c_x_stb));

    // Count cycles spent on Calx; remember whether the op was aborted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= 32'd0;
            err_q <= 1'b0;
        end else begin
            if (state == ST_ISSUE || state == ST_WAIT) begin
                cnt <= cnt + 32'd1;
            end else begin
                cnt <= 32'd0;
            end
            if (grant_go) begin
                err_q <= 1'b0;
            end else if (tmo) begin
                err_q <= 1'b1;
            end
        end
    end

    assign res0_err = res0_stb && err_q;
    assign res1_err = res1_stb && err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign tmo      = 1'b0;
    assign res0_err = 1'b0;
    assign res1_err = 1'b0;
`endif

    // Main control: grant, issue, wait for Calx, hand back the result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            owner <= 1'b0;
            ops   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_go) begin
                        owner <= gnt[1];
                        ops   <= gnt[1] ? in1 : in0;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (c_ack) begin
                        state <= ST_WAIT;
                    end else if (tmo) begin
                        state <= ST_RETURN;
                    end
                end
                ST_WAIT: begin
                    if (load) begin
                        state <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    if (owner ? res1_ack : res0_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result registers, one per requester, held until overwritten.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x0 <= 64'd0;
            x1 <= 64'd0;
        end else if (load) begin
            if (owner) begin
                x1 <= ret_x;
            end else begin
                x0 <= ret_x;
            end
        end
    end

endmodule

// File: tb/tb_calx_arbiter.sv
// tb_calx_arbiter: directed scoreboard bench for calx_arbiter.
// Honours CALX_ARB_TIMEOUT_EN for the stuck-Calx case.
module tb_calx_arbiter;
    import calx_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_stb, req1_stb, res0_ack, res1_ack;
    logic        c_ack, c_x_stb;
    logic [63:0] c_x;
    calx_ops_t   in0, in1;
    logic        req0_ack, req1_ack, res0_stb, res1_stb;
    logic        res0_err, res1_err, c_stb, c_x_ack;
    logic [63:0] res0_x, res1_x, c_z, c_r, c_dss, c_z0square;

    calx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req0_stb(req0_stb), .req0_ack(req0_ack),
        .req0_z(in0.z), .req0_r(in0.r),
        .req0_dss(in0.dss), .req0_z0square(in0.z0square),
        .res0_x(res0_x), .res0_stb(res0_stb),
        .res0_ack(res0_ack), .res0_err(res0_err),
        .req1_stb(req1_stb), .req1_ack(req1_ack),
        .req1_z(in1.z), .req1_r(in1.r),
        .req1_dss(in1.dss), .req1_z0square(in1.z0square),
        .res1_x(res1_x), .res1_stb(res1_stb),
        .res1_ack(res1_ack), .res1_err(res1_err),
        .c_stb(c_stb), .c_z(c_z), .c_r(c_r),
        .c_dss(c_dss), .c_z0square(c_z0square),
        .c_ack(c_ack), .c_x(c_x), .c_x_stb(c_x_stb),
        .c_x_ack(c_x_ack)
    );

    typedef struct {
        int          n;
        logic [63:0] x;
        logic        err;
    } exp_t;

    exp_t      sb[$];
    calx_ops_t sent[2];
    int        tests = 0;
    int        fails = 0;

    task automatic check(input string tag,
                         input logic [255:0] obs,
                         input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bench's Calx behaviour: a fixed mixing of the operands.
    function automatic logic [63:0] calx_fn(input calx_ops_t o);
        return (o.z + 64'h0010_0000_0000_0000) ^ o.r ^ o.dss ^ o.z0square;
    endfunction

    function automatic calx_ops_t rnd_ops();
        calx_ops_t o;
        o.z        = {$urandom, $urandom};
        o.r        = {$urandom, $urandom};
        o.dss      = {$urandom, $urandom};
        o.z0square = {$urandom, $urandom};
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic request(input int n, input calx_ops_t o);
        sent[n] = o;
        if (n == 1) begin
            in1 = o;
            req1_stb = 1'b1;
        end else begin
            in0 = o;
            req0_stb = 1'b1;
        end
    endtask

    task automatic expect_res(input int n, input logic [63:0] x, input logic e);
        exp_t r;
        r.n = n;
        r.x = x;
        r.err = e;
        sb.push_back(r);
    endtask

    task automatic check_res(input string tag, input exp_t e);
        check({tag, "_stb"}, {res1_stb, res0_stb}, (e.n == 1) ? 2'b10 : 2'b01);
        check({tag, "_x"}, (e.n == 1) ? res1_x : res0_x, e.x);
        check({tag, "_err"}, {res1_err, res0_err}, e.err ? ((e.n == 1) ? 2'b10 : 2'b01) : 2'b00);
    endtask

    // One full transaction for the requester at the scoreboard head.
    task automatic serve(input int ack_dly, input int bp);
        exp_t        e;
        calx_ops_t   o;
        logic [63:0] got;
        e = sb[0];
        o = sent[e.n];
        #1;
        check("grant", {req1_ack, req0_ack}, (e.n == 1) ? 2'b10 : 2'b01);
        step();
        if (e.n == 1) req1_stb = 1'b0; else req0_stb = 1'b0;
        #1;
        check("ack_pulse", {req1_ack, req0_ack}, 2'b00);
        check("issue", {c_stb, c_x_ack}, 2'b10);
        check("c_ops", {c_z, c_r, c_dss, c_z0square}, o);
        for (int i = 0; i < ack_dly; i++) begin
            step();
            #1;
            check("c_hold", {c_stb, c_x_ack}, 2'b10);
            check("c_ops_hold", {c_z, c_r, c_dss, c_z0square}, o);
        end
        c_ack = 1'b1;
        step();
        c_ack = 1'b0;
        #1;
        check("wait", {c_stb, c_x_ack}, 2'b01);
        c_x = calx_fn({c_z, c_r, c_dss, c_z0square});
        c_x_stb = 1'b1;
        step();
        c_x_stb = 1'b0;
        c_x = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        e = sb.pop_front();
        check_res("res", e);
        got = (e.n == 1) ? res1_x : res0_x;
        for (int i = 0; i < bp; i++) begin
            step();
            #1;
            check("bp_stb", {res1_stb, res0_stb}, (e.n == 1) ? 2'b10 : 2'b01);
            check("bp_x", (e.n == 1) ? res1_x : res0_x, got);
            check("bp_noack", {req1_ack, req0_ack, c_stb}, 3'b000);
        end
        if (e.n == 1) res1_ack = 1'b1; else res0_ack = 1'b1;
        step();
        res0_ack = 1'b0;
        res1_ack = 1'b0;
        #1;
        check("res_drop", {res1_stb, res0_stb}, 2'b00);
    endtask

    initial begin
        calx_ops_t o;
        rst = 1'b0;
        {req0_stb, req1_stb, res0_ack, res1_ack} = '0;
        {c_ack, c_x_stb} = '0;
        c_x = '0;
        in0 = '0;
        in1 = '0;
        repeat (3) step();
        #1;
        check("rst_ctl", {req0_ack, req1_ack, c_stb, c_x_ack,
                          res0_stb, res1_stb, res0_err, res1_err}, 8'h00);
        check("rst_x", {res0_x, res1_x}, 128'd0);
        check("rst_ops", {c_z, c_r, c_dss, c_z0square}, 256'd0);
        rst = 1'b1;
        step();

        // Tie straight after reset: req0 first, then req1.
        request(0, rnd_ops());
        request(1, rnd_ops());
        expect_res(0, calx_fn(sent[0]), 1'b0);
        expect_res(1, calx_fn(sent[1]), 1'b0);
        serve(2, 0);
        serve(0, 1);

        // Second tie: req0 again, only after req1 was served.
        request(0, rnd_ops());
        request(1, rnd_ops());
        expect_res(0, calx_fn(sent[0]), 1'b0);
        expect_res(1, calx_fn(sent[1]), 1'b0);
        serve(0, 0);
        serve(1, 0);

        // Single request with known operand and result.
        o = '0;
        o.z = 64'h3FF0_0000_0000_0000;
        request(0, o);
        expect_res(0, 64'h4000_0000_0000_0000, 1'b0);
        serve(0, 3);

        // Tie with pointer at req0: req1 wins, slow c_ack, long back-pressure.
        request(0, rnd_ops());
        request(1, rnd_ops());
        expect_res(1, calx_fn(sent[1]), 1'b0);
        expect_res(0, calx_fn(sent[0]), 1'b0);
        serve(5, 10);
        serve(0, 0);

        // Lone req0 is granted even though the pointer favours req1.
        request(0, rnd_ops());
        expect_res(0, calx_fn(sent[0]), 1'b0);
        serve(1, 0);

        // Reset while waiting on Calx abandons the operation.
        request(0, rnd_ops());
        #1;
        check("rw_grant", {req1_ack, req0_ack}, 2'b01);
        step();
        req0_stb = 1'b0;
        c_ack = 1'b1;
        step();
        c_ack = 1'b0;
        #1;
        check("rw_wait", {c_stb, c_x_ack}, 2'b01);
        rst = 1'b0;
        step();
        #1;
        check("rw_ctl", {req0_ack, req1_ack, c_stb, c_x_ack,
                         res0_stb, res1_stb, res0_err, res1_err}, 8'h00);
        check("rw_x", {res0_x, res1_x}, 128'd0);
        check("rw_ops", {c_z, c_r, c_dss, c_z0square}, 256'd0);
        rst = 1'b1;
        c_x = 64'h1234_5678_9ABC_DEF0;
        c_x_stb = 1'b1;
        step();
        c_x_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rw_nores", {res1_stb, res0_stb, c_x_ack}, 3'b000);
            step();
        end

        // Pointer was restored by reset: req0 wins this tie.
        request(0, rnd_ops());
        request(1, rnd_ops());
        expect_res(0, calx_fn(sent[0]), 1'b0);
        expect_res(1, calx_fn(sent[1]), 1'b0);
        serve(0, 0);
        serve(0, 0);

        // Calx never answers.
        request(0, rnd_ops());
        #1;
        check("to_grant", {req1_ack, req0_ack}, 2'b01);
        step();
        req0_stb = 1'b0;
`ifdef CALX_ARB_TIMEOUT_EN
        expect_res(0, 64'd0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            #1;
            check("to_pending", {res1_stb, res0_stb}, 2'b00);
            step();
        end
        step();
        #1;
        check("to_cstb", c_stb, 1'b0);
        check_res("to", sb.pop_front());
        res0_ack = 1'b1;
        step();
        res0_ack = 1'b0;
        #1;
        check("to_drop", {res1_stb, res0_stb}, 2'b00);
`else
        for (int i = 0; i < 40; i++) begin
            #1;
            check("hang_nores", {res1_stb, res0_stb, c_stb}, 3'b001);
            step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
`endif
        check("sb_empty", 256'(sb.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, required earlier finish");
        $fatal(1);
    end

endmodule

// File: doc/calx_arbiter.md
CALX_ARBITER -- requirements
Module: calx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 2000, cycles allowed from Calx issue to Calx result before abort (used only with CALX_ARB_TIMEOUT_EN).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port: clk  in  1  clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  synchronous reset, active-low.
REQ-005 Port: reqN_stb  in  1  requester N (N=0,1) operands valid; held high until reqN_ack.
REQ-006 Port: reqN_ack  out  1  one-cycle pulse; operands of requester N captured.
REQ-007 Port: reqN_z, reqN_r, reqN_dss, reqN_z0square  in  64 each  requester N operands.
REQ-008 Port: resN_x  out  64  result returned to requester N.
REQ-009 Port: resN_stb  out  1  result valid for requester N; held until resN_ack.
REQ-010 Port: resN_ack  in  1  requester N accepts result.
REQ-011 Port: resN_err  out  1  aborted-operation flag, qualified by resN_stb.
REQ-012 Port: c_stb, c_z, c_r, c_dss, c_z0square  out  1/64/64/64/64  request and operands to the shared Calx unit.
REQ-013 Port: c_ack  in  1  Calx accepted request.
REQ-014 Port: c_x  in  64  Calx result.
REQ-015 Port: c_x_stb  in  1  Calx result valid.
REQ-016 Port: c_x_ack  out  1  result accept to Calx.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, RETURN.
REQ-018 IDLE: if any reqN_stb, grant one requester, latch its operands, pulse reqN_ack for exactly one cycle, record the grant, go to ISSUE.
REQ-019 Arbitration: round-robin. If both stb are high, grant the requester not granted last; a single requester is granted regardless of the pointer.
REQ-020 A requester not granted SHALL see reqN_ack=0 until it is granted; its stb is not dropped by the block.
REQ-021 ISSUE: c_stb=1 with latched operands stable; on c_ack=1, c_stb=0 next cycle, go to WAIT.
REQ-022 WAIT: c_x_ack=1; on c_x_stb=1 latch c_x into resN_x of the granted requester, go to RETURN.
REQ-023 RETURN: resN_stb=1 for the granted requester only; on resN_ack=1 deassert next cycle, go to IDLE.
REQ-024 Only one operation SHALL be in flight; the next grant is possible in the cycle after RETURN exits.
REQ-025 Latency: c_stb rises exactly one cycle after the reqN_ack pulse; resN_stb rises exactly one cycle after c_x_stb is sampled.
REQ-026 Data passes bit-exact; the block performs no arithmetic on operands or result.

Reset
REQ-027 While rst=0: state=IDLE; all ack, stb, err and c_x_ack outputs are 0; resN_x=0; c_* operands=0; round-robin pointer set so requester 0 wins the first tie.
REQ-028 Reset mid-operation SHALL abandon the in-flight operation without delivering any result.

Configuration
REQ-029 Macro CALX_ARB_TIMEOUT_EN defined: a counter runs in ISSUE and WAIT and clears on entry to ISSUE; when it reaches TIMEOUT_CYCLES, c_stb=0, go to RETURN with resN_x=0 and resN_err=1.
REQ-030 Without CALX_ARB_TIMEOUT_EN: no counter; ISSUE and WAIT wait indefinitely; resN_err is tied to 0.

Structure
REQ-031 The shared package calx_pkg SHALL hold the operand struct (z, r, dss, z0square; 64-bit each), the FSM state enum and the default TIMEOUT_CYCLES constant.
REQ-032 The sub-module rr_arb2 (2-way round-robin grant with pointer register) SHALL be the only sub-module; Calx is instantiated outside this block.

Verification
REQ-033 Single request: req0 with z=0x3FF0000000000000, Calx model returns 0x4000000000000000 -> req0_ack one pulse, res0_x=0x4000000000000000, res0_stb held until res0_ack; res1_stb stays 0.
REQ-034 Simultaneous req0 and req1 after reset -> req0 granted first, req1 granted after res0 handshake; a second tie grants req0 again only after req1 has been served.
REQ-035 Back-pressure: res1_ack held low 10 cycles -> res1_stb and res1_x stable for all 10 cycles; no new reqN_ack during this time.
REQ-036 Calx delays c_ack 5 cycles -> c_stb and c_* operands stable until c_ack; exactly one issue per grant.
REQ-037 Reset asserted in WAIT -> next cycle all outputs 0 and state IDLE; a later c_x_stb produces no resN_stb.
REQ-038 With CALX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, Calx never responds -> res0_stb=1, res0_err=1, res0_x=0 after 16 cycles; without the macro, no response ever appears.
